// File: rtl/clock24_pkg.sv
// Shared definitions for the clock24 seven-segment display path.
// Segment encodings are {g,f,e,d,c,b,a}, active-high.
// Digit index order matches the anode order: minutes units first, hours tens last.
package clock24_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        DIG_MIN1   = 2'd0,
        DIG_MIN10  = 2'd1,
        DIG_HOUR1  = 2'd2,
        DIG_HOUR10 = 2'd3
    } digit_e;

    // Element n is the one-hot anode pattern for digit index n.
    localparam logic [3:0][3:0] AN_ONEHOT = {4'b1000, 4'b0100, 4'b0010, 4'b0001};

endpackage

// File: rtl/clock24_display_bcd_to_7seg.sv
// BCD digit to seven-segment decoder; values above 9 show a dash.
// Latency: purely combinational.
// Backpressure: none.
module bcd_to_7seg
    import clock24_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup, anything out of BCD range falls through to the dash.
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock24_display.sv
// Multiplexed 4-digit HH:MM seven-segment driver with per-frame input snapshot.
// Latency: outputs registered, one cycle after the scan index/snapshot they decode.
// Backpressure: none; free-running scan. Optional LEAD_ZERO_BLANK_EN blanks a zero hours-tens digit.
module clock24_display
    import clock24_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int CNT_W    = $clog2(SCAN_DIV) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min1,
    input  logic [2:0] min10,
    input  logic [3:0] hour1,
    input  logic [1:0] hour10,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    digit_e           idx;
    logic [3:0]       snap_min1;
    logic [2:0]       snap_min10;
    logic [3:0]       snap_hour1;
    logic [1:0]       snap_hour10;

    logic             digit_wrap;
    logic             frame_end;
    logic [3:0]       digit;
    logic [6:0]       dec_seg;
    logic [6:0]       seg_next;

    assign digit_wrap = (cnt == CNT_MAX);
    assign frame_end  = digit_wrap && (idx == DIG_HOUR10);

    // Select the snapshot digit for the current scan slot, zero-extended.
    always_comb begin
        digit = 4'd0;
        case (idx)
            DIG_MIN1:   digit = snap_min1;
            DIG_MIN10:  digit = {1'b0, snap_min10};
            DIG_HOUR1:  digit = snap_hour1;
            DIG_HOUR10: digit = {2'b00, snap_hour10};
            default:    digit = 4'd0;
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd (digit),
        .seg (dec_seg)
    );

    // Segment value for the slot, with optional leading-zero blanking of hours tens.
    always_comb begin
        seg_next = dec_seg;
`ifdef LEAD_ZERO_BLANK_EN
        if ((idx == DIG_HOUR10) && (snap_hour10 == 2'd0)) begin
            seg_next = SEG_BLANK;
        end
`endif
    end

    // Prescaler and digit index: hold each digit for SCAN_DIV cycles, then advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= DIG_MIN1;
        end else if (digit_wrap) begin
            cnt <= '0;
            idx <= digit_e'(idx + 2'd1);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Capture inputs only at frame end so a frame never mixes two times.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_min1   <= 4'd0;
            snap_min10  <= 3'd0;
            snap_hour1  <= 4'd0;
            snap_hour10 <= 2'd0;
        end else if (frame_end) begin
            snap_min1   <= min1;
            snap_min10  <= min10;
            snap_hour1  <= hour1;
            snap_hour10 <= hour10;
        end
    end

    // Registered display outputs; the colon rides with the hours-units digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= 7'd0;
            an  <= 4'd0;
            dp  <= 1'b0;
        end else begin
            seg <= seg_next;
            an  <= AN_ONEHOT[idx];
            dp  <= (idx == DIG_HOUR1);
        end
    end

endmodule

// File: doc/clock24_display.md
Name: clock24_display

Overview:
- Consumes the BCD time digits produced by the clock24 counter (min1, min10, hour1, hour10).
- Drives a 4-digit multiplexed seven-segment display with hour:minute separated by a colon.
- Time-multiplexes one digit at a time using a prescaled scan counter.
- Captures a per-frame snapshot of the inputs so a digit never tears mid-frame.

Parameters:
- SCAN_DIV, default 4: clock cycles each digit is held; legal values are 1 or more; one frame lasts 4*SCAN_DIV cycles.
- CNT_W, default $clog2(SCAN_DIV)+1: prescaler width; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- min1  in  4  BCD minutes units, 0-9.
- min10  in  3  BCD minutes tens, 0-5.
- hour1  in  4  BCD hours units, 0-9.
- hour10  in  2  BCD hours tens, 0-2.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- an  out  4  one-hot digit enable, active-high; an[0]=min1, an[1]=min10, an[2]=hour1, an[3]=hour10.
- dp  out  1  colon/decimal point, active-high.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: seg=0, an=0, dp=0, prescaler cnt=0, digit index idx=0, snapshot=00:00.
- Prescaler: cnt increments every cycle. When cnt==SCAN_DIV-1 it wraps to 0 and idx advances 0→1→2→3→0. With SCAN_DIV=1, idx advances every cycle.
- Snapshot: loaded from all four inputs on the edge where cnt==SCAN_DIV-1 and idx==3, i.e. at the end of a frame. Input changes at any other time are invisible until the next frame.
- The first frame after reset shows the snapshot reset value, 00:00. Live values appear from the second frame.
- Outputs are registered: seg/an/dp at edge t+1 = decode(idx(t), snapshot(t)). The first non-reset edge drives an=0001. Each an value is then held for exactly SCAN_DIV cycles.
- Digit selection: the selected digit is zero-extended to 4 bits and decoded.
- Decode table (seg):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - any value above 9 = 0x40 (dash)
- dp=1 only while an=0100 (colon after the hours digit); otherwise dp=0.
- Reset mid-frame: on the next edge the outputs and all state return to their reset values, and scanning restarts at idx 0.
- Exactly one bit of an is high at any time outside reset.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: when the hour10 snapshot is 0, seg=0x00 during the an=1000 window; an[3] is still asserted. No other digit is ever blanked.
- Undefined: hour10=0 displays 0x3F as normal.

Decomposition:
- Package clock24_pkg holds:
  - SEG_0..SEG_9 and SEG_DASH as 7-bit localparams;
  - digit index enum (DIG_MIN1, DIG_MIN10, DIG_HOUR1, DIG_HOUR10);
  - AN_ONEHOT lookup.
- Sub-module bcd_to_7seg: purely combinational, 4-bit in, 7-bit out.
- Scan, snapshot and output registers stay in clock24_display.

Test Plan (SCAN_DIV=4 unless stated):
- Inputs 12:34, reset high 3 cycles then low:
  - during reset, an=0/seg=0/dp=0;
  - first 16 cycles show 00:00: an 0001, 0010, 0100, 1000, each for 4 cycles, seg=0x3F, dp=1 only with an=0100;
  - second frame: 0001/0x66, 0010/0x4F, 0100/0x5B dp=1, 1000/0x06.
- Inputs switch 12:34→23:59 while an=0010: the rest of the frame still shows 3, 2, 1; the next frame shows 0x6F, 0x6D, 0x4F (dp=1), 0x5B.
- min1=4'hC: digit 0 window shows seg=0x40; the other digits are unaffected.
- reset asserted for 1 cycle while an=0100: next edge an=0, seg=0, dp=0; after release, scanning restarts at an=0001 with snapshot 00:00.
- Input 09:45:
  - with LEAD_ZERO_BLANK_EN, the an=1000 window shows seg=0x00;
  - without it, seg=0x3F;
  - the hour1 window shows 0x6F in both builds.
- SCAN_DIV=1, 21:07: an rotates every cycle (0001, 0010, 0100, 1000, repeat) with a frame period of 4 cycles; after the first frame the sequence is seg 0x07, 0x3F, 0x06 dp=1, 0x5B.
